spi_txn_arbiter: RTL and testbench

Shares one bidirectional (half-duplex) SPI transaction core between NUM_REQ fabric-side requesters, for example a DAC config path, a gradient-board readback path and a debug register path.
- Arbitrates round-robin and issues one transaction at a time to the core.
- Waits for the core to go busy and then idle, and collects read-back data when the rw mask implies a read.
- Returns a response, with a timeout error, to the requester that owned the transaction.
- Sits in the fabric_clk domain, directly in front of the SPI core's transaction_* inputs.

---
 rtl/spi_arb_pkg.sv | 30 +++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/spi_txn_arbiter.sv | 168 ++++++++++++++++
 tb/tb_spi_txn_arbiter.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
// Shared types and helpers for the SPI transaction arbiter.
// Holds the FSM state encoding and the read-detection rule applied to a latched request.
package spi_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_START,
    WAIT_DONE,
    WAIT_READ,
    RESPOND
  } arb_state_t;

  localparam int DEFAULT_TIMEOUT_CYCLES = 4096;
  localparam int TIMEOUT_W              = $clog2(DEFAULT_TIMEOUT_CYCLES);
  localparam int MAX_DATA_WIDTH         = 64;

  // A transaction reads if any of its top len mask bits is 0 (bits shift out MSB first).
  function automatic logic read_expected(input int unsigned len,
                                         input logic [MAX_DATA_WIDTH-1:0] mask,
                                         input int unsigned width);
    logic rd;
    rd = 1'b0;
    for (int unsigned i = 0; i < MAX_DATA_WIDTH; i++) begin
      if ((i < width) && ((i + len) >= width)) rd = rd | ~mask[i];
    end
    return rd;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a one-hot grant; the pointer moves to the winner on advance.
// The search starts just after the last winner, so after reset requester 0 ranks first.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic               fabric_clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] win_idx;
  logic [PTR_W-1:0] cand;
  logic             found;

  always_comb begin
    grant   = '0;
    win_idx = ptr_q;
    found   = 1'b0;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        win_idx     = cand;
      end
    end
  end

  always_ff @(posedge fabric_clk or posedge reset) begin
    if (reset) begin
      ptr_q <= PTR_W'(NUM_REQ - 1);
    end else if (advance && found) begin
      ptr_q <= win_idx;
    end
  end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Shares one half-duplex SPI transaction core between NUM_REQ fabric requesters,
// one transaction at a time, returning read data or a timeout error to the owner.
module spi_txn_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ               = 4,
  parameter int DATA_WIDTH            = 32,
  parameter int TRANSACTION_LEN_WIDTH = 6,
  parameter int TIMEOUT_CYCLES        = 4096
) (
  input  logic                                       fabric_clk,
  input  logic                                       reset,
  input  logic [NUM_REQ-1:0]                         req_valid,
  output logic [NUM_REQ-1:0]                         req_ready,
  input  logic [NUM_REQ*TRANSACTION_LEN_WIDTH-1:0]   req_length,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]              req_data,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]              req_rw_mask,
  output logic [NUM_REQ-1:0]                         rsp_valid,
  output logic [DATA_WIDTH-1:0]                      rsp_data,
  output logic                                       rsp_error,
  output logic [TRANSACTION_LEN_WIDTH-1:0]           spi_transaction_length,
  output logic [DATA_WIDTH-1:0]                      spi_transaction_data,
  output logic [DATA_WIDTH-1:0]                      spi_transaction_rw_mask,
  input  logic                                       spi_busy,
  input  logic                                       spi_read_valid,
  input  logic [DATA_WIDTH-1:0]                      spi_read_data
);

  localparam int LW    = TRANSACTION_LEN_WIDTH;
  localparam int CNT_W = (TIMEOUT_CYCLES > DEFAULT_TIMEOUT_CYCLES) ? $clog2(TIMEOUT_CYCLES) : TIMEOUT_W;

  arb_state_t state_q, state_d;

  logic [NUM_REQ-1:0]        grant;
  logic [NUM_REQ-1:0]        owner_q;
  logic                      accept;
  logic [LW-1:0]             sel_len, clamp_len, len_q;
  logic [DATA_WIDTH-1:0]     sel_data, sel_mask;
  logic [DATA_WIDTH-1:0]     data_q, mask_q, rdata_q;
  logic [MAX_DATA_WIDTH-1:0] mask_ext;
  logic                      sel_rexp, rexp_q, read_seen_q, err_q;
  logic                      timeout_hit, cnt_at_limit, in_wait;
  logic [CNT_W-1:0]          cnt_q;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .fabric_clk (fabric_clk),
    .reset      (reset),
    .req        (req_valid),
    .advance    (accept),
    .grant      (grant)
  );

  assign accept       = (state_q == IDLE) && (|grant);
  assign in_wait      = (state_q == WAIT_START) || (state_q == WAIT_DONE) || (state_q == WAIT_READ);
  assign cnt_at_limit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Winner's payload, with the length clamped to the shift register width.
  always_comb begin
    sel_len  = '0;
    sel_data = '0;
    sel_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_len  = req_length[i*LW +: LW];
        sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_mask = req_rw_mask[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    clamp_len = (int'(sel_len) > DATA_WIDTH) ? LW'(DATA_WIDTH) : sel_len;
    mask_ext  = '0;
    mask_ext[DATA_WIDTH-1:0] = sel_mask;
    sel_rexp  = read_expected(32'(clamp_len), mask_ext, DATA_WIDTH);
  end

  always_ff @(posedge fabric_clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // A real core event always beats the timeout when both land on the same cycle.
  always_comb begin
    state_d     = state_q;
    timeout_hit = 1'b0;
    case (state_q)
      IDLE:       if (accept) state_d = (clamp_len == '0) ? RESPOND : ISSUE;
      ISSUE:      state_d = WAIT_START;
      WAIT_START: begin
        if (spi_busy) state_d = WAIT_DONE;
        else if (cnt_at_limit) begin
          state_d     = RESPOND;
          timeout_hit = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!spi_busy)
          state_d = (rexp_q && !read_seen_q && !spi_read_valid) ? WAIT_READ : RESPOND;
        else if (cnt_at_limit) begin
          state_d     = RESPOND;
          timeout_hit = 1'b1;
        end
      end
      WAIT_READ: begin
        if (spi_read_valid) state_d = RESPOND;
        else if (cnt_at_limit) begin
          state_d     = RESPOND;
          timeout_hit = 1'b1;
        end
      end
      RESPOND:    state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready              = '0;
    rsp_valid              = '0;
    rsp_data               = '0;
    rsp_error              = 1'b0;
    spi_transaction_length = '0;
    case (state_q)
      IDLE:    req_ready = grant;
      ISSUE:   spi_transaction_length = len_q;
      RESPOND: begin
        rsp_valid = owner_q;
        rsp_error = err_q;
        rsp_data  = (rexp_q && !err_q) ? rdata_q : '0;
      end
      default: ;
    endcase
  end

  assign spi_transaction_data    = data_q;
  assign spi_transaction_rw_mask = mask_q;

  // Per-transaction context; only the first read-back pulse in a transaction is kept.
  always_ff @(posedge fabric_clk or posedge reset) begin
    if (reset) begin
      owner_q     <= '0;
      len_q       <= '0;
      data_q      <= '0;
      mask_q      <= '0;
      rexp_q      <= 1'b0;
      read_seen_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      if (accept) begin
        owner_q     <= grant;
        len_q       <= clamp_len;
        data_q      <= sel_data;
        mask_q      <= sel_mask;
        rexp_q      <= sel_rexp;
        read_seen_q <= 1'b0;
        rdata_q     <= '0;
        err_q       <= 1'b0;
      end
      if ((state_q == WAIT_DONE || state_q == WAIT_READ) && spi_read_valid && !read_seen_q) begin
        read_seen_q <= 1'b1;
        rdata_q     <= spi_read_data;
      end
      if (timeout_hit) err_q <= 1'b1;
      if (state_d != state_q)          cnt_q <= '0;
      else if (in_wait && !cnt_at_limit) cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Self-checking bench for spi_txn_arbiter: the bench plays the SPI core and compares
// responses against timings and data derived from the arbiter's transaction rules.
module tb_spi_txn_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int LW = 6;
  localparam int TO = 64;

  logic              fabric_clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*LW-1:0]  req_length;
  logic [NR*DW-1:0]  req_data;
  logic [NR*DW-1:0]  req_rw_mask;
  logic [NR-1:0]     rsp_valid;
  logic [DW-1:0]     rsp_data;
  logic              rsp_error;
  logic [LW-1:0]     spi_transaction_length;
  logic [DW-1:0]     spi_transaction_data;
  logic [DW-1:0]     spi_transaction_rw_mask;
  logic              spi_busy;
  logic              spi_read_valid;
  logic [DW-1:0]     spi_read_data;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    int          r;
    int          len;
    logic [31:0] data;
    logic [31:0] mask;
    int          sd;
    int          bl;
    bit          never;
    bit          rpulse;
    int          roff;
    logic [31:0] rd1;
    bit          second;
    logic [31:0] rd2;
  } stim_t;

  typedef struct {
    int          acc;
    int          pulse_cnt;
    int          pulse_cyc;
    int          pulse_len;
    logic [31:0] tdata;
    logic [31:0] tmask;
    int          rsp_cnt;
    int          rsp_cyc;
    logic [3:0]  rsp_vec;
    logic [31:0] rdata;
    logic        rerr;
    bit          hung;
  } obs_t;

  spi_txn_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .TRANSACTION_LEN_WIDTH(LW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .fabric_clk              (fabric_clk),
    .reset                   (reset),
    .req_valid               (req_valid),
    .req_ready               (req_ready),
    .req_length              (req_length),
    .req_data                (req_data),
    .req_rw_mask             (req_rw_mask),
    .rsp_valid               (rsp_valid),
    .rsp_data                (rsp_data),
    .rsp_error               (rsp_error),
    .spi_transaction_length  (spi_transaction_length),
    .spi_transaction_data    (spi_transaction_data),
    .spi_transaction_rw_mask (spi_transaction_rw_mask),
    .spi_busy                (spi_busy),
    .spi_read_valid          (spi_read_valid),
    .spi_read_data           (spi_read_data)
  );

  always #5 fabric_clk = ~fabric_clk;

  function automatic int exp_len(input int l);
    return (l > DW) ? DW : l;
  endfunction

  // Reads happen when any of the top l mask bits is 0.
  function automatic bit exp_read(input int l, input logic [31:0] mask);
    logic [63:0] inv;
    if (l == 0) return 1'b0;
    inv = {32'h0, ~mask};
    return ((inv >> (DW - l)) & ((64'd1 << l) - 64'd1)) != 64'd0;
  endfunction

  // Response cycle: accept -> one ISSUE cycle -> busy window -> optional read wait -> RESPOND.
  function automatic int exp_rsp_cyc(input int acc, input stim_t s, input bit rexp);
    int f;
    if (exp_len(s.len) == 0) return acc + 1;
    f = acc + 1 + s.sd + s.bl;
    return f + ((rexp && s.roff > 0) ? s.roff : 0) + 1;
  endfunction

  function automatic stim_t base_stim(input int r, input int len, input logic [31:0] data,
                                      input logic [31:0] mask);
    stim_t s;
    s.r = r; s.len = len; s.data = data; s.mask = mask;
    s.sd = 1; s.bl = 6; s.never = 1'b0; s.rpulse = 1'b0; s.roff = 0;
    s.rd1 = '0; s.second = 1'b0; s.rd2 = '0;
    return s;
  endfunction

  task automatic apply_reset();
    reset = 1'b1;
    req_valid = '0; req_length = '0; req_data = '0; req_rw_mask = '0;
    spi_busy = 1'b0; spi_read_valid = 1'b0; spi_read_data = '0;
    repeat (3) @(negedge fabric_clk);
    reset = 1'b0;
  endtask

  // Drives one request, acts as the SPI core, and records what the arbiter did.
  task automatic do_txn(input stim_t s, output obs_t o);
    int f;
    bit fin;
    o.acc = -1; o.pulse_cnt = 0; o.pulse_cyc = -1; o.pulse_len = 0;
    o.tdata = '0; o.tmask = '0; o.rsp_cnt = 0; o.rsp_cyc = -1;
    o.rsp_vec = '0; o.rdata = '0; o.rerr = 1'b0; o.hung = 1'b0;
    @(negedge fabric_clk);
    req_length[s.r*LW +: LW]  = LW'(s.len);
    req_data[s.r*DW +: DW]    = s.data;
    req_rw_mask[s.r*DW +: DW] = s.mask;
    req_valid[s.r]            = 1'b1;
    #1;
    fin = 1'b0;
    for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
      if (cyc > 0) begin
        @(negedge fabric_clk);
        #1;
      end
      if (o.acc < 0 && req_ready[s.r] && req_valid[s.r]) o.acc = cyc;
      if (spi_transaction_length != '0) begin
        o.pulse_cnt++;
        if (o.pulse_cyc < 0) begin
          o.pulse_cyc = cyc;
          o.pulse_len = int'(spi_transaction_length);
          o.tdata     = spi_transaction_data;
          o.tmask     = spi_transaction_rw_mask;
        end
      end
      if (rsp_valid != '0) begin
        o.rsp_cnt++;
        if (o.rsp_cyc < 0) begin
          o.rsp_cyc = cyc; o.rsp_vec = rsp_valid; o.rdata = rsp_data; o.rerr = rsp_error;
        end
      end
      if (o.rsp_cyc >= 0 && cyc >= o.rsp_cyc + 2) fin = 1'b1;
      if (o.acc >= 0 && cyc > o.acc) req_valid[s.r] = 1'b0;
      f = o.pulse_cyc + s.sd + s.bl;
      spi_busy = (o.pulse_cyc >= 0) && !s.never && (cyc >= o.pulse_cyc + s.sd) && (cyc < f);
      spi_read_valid = 1'b0;
      spi_read_data  = '0;
      if (o.pulse_cyc >= 0 && s.rpulse && cyc == f + s.roff) begin
        spi_read_valid = 1'b1; spi_read_data = s.rd1;
      end else if (o.pulse_cyc >= 0 && s.second && cyc == f + s.roff + 1) begin
        spi_read_valid = 1'b1; spi_read_data = s.rd2;
      end
    end
    o.hung = !fin;
    req_valid = '0; spi_busy = 1'b0; spi_read_valid = 1'b0; spi_read_data = '0;
  endtask

  // Compares one finished transaction against the expectations derived from its stimulus.
  task automatic judge(input string tag, input stim_t s, input obs_t o, input bit exp_err,
                       input int exp_cyc);
    bit          rexp;
    logic [31:0] exp_d;
    int          el;
    rexp  = exp_read(exp_len(s.len), s.mask);
    el    = exp_len(s.len);
    exp_d = (rexp && !exp_err) ? s.rd1 : 32'h0;
    vectors++;
    if (o.hung) begin
      miscompares++; $display("[TB] FAIL %s_done: no response within bound (got hung=1, need 0)", tag);
    end
    vectors++;
    if (o.pulse_cnt !== ((el == 0) ? 0 : 1)) begin
      miscompares++; $display("[TB] FAIL %s_pulse_count: got %0d need %0d", tag, o.pulse_cnt, (el == 0) ? 0 : 1);
    end
    if (el != 0) begin
      vectors++;
      if (o.pulse_len !== el || o.pulse_cyc !== o.acc + 1) begin
        miscompares++;
        $display("[TB] FAIL %s_length: got len %0d at cyc %0d, need len %0d at cyc %0d", tag, o.pulse_len, o.pulse_cyc, el, o.acc + 1);
      end
      vectors++;
      if (o.tdata !== s.data || o.tmask !== s.mask) begin
        miscompares++;
        $display("[TB] FAIL %s_payload: got %h/%h need %h/%h", tag, o.tdata, o.tmask, s.data, s.mask);
      end
    end
    vectors++;
    if (o.rsp_vec !== 4'(1 << s.r) || o.rsp_cnt !== 1) begin
      miscompares++;
      $display("[TB] FAIL %s_rsp_valid: got %b x%0d need %b x1", tag, o.rsp_vec, o.rsp_cnt, 4'(1 << s.r));
    end
    vectors++;
    if (o.rdata !== exp_d || o.rerr !== exp_err) begin
      miscompares++;
      $display("[TB] FAIL %s_rsp_data: got %h err %b need %h err %b", tag, o.rdata, o.rerr, exp_d, exp_err);
    end
    vectors++;
    if (o.rsp_cyc !== exp_cyc) begin
      miscompares++; $display("[TB] FAIL %s_rsp_time: got cyc %0d need %0d", tag, o.rsp_cyc, exp_cyc);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = '0; spi_busy = 1'b0; spi_read_valid = 1'b0;
    #1;
    vectors++;
    if ({req_ready, rsp_valid, rsp_data, rsp_error, spi_transaction_length,
         spi_transaction_data, spi_transaction_rw_mask} !== '0) begin
      miscompares++; $display("[TB] FAIL reset_outputs: got nonzero outputs, need all 0");
    end
    apply_reset();
  endtask

  task automatic test_single_write();
    stim_t s; obs_t o;
    s = base_stim(0, 16, 32'hA5A50000, 32'hFFFF0000);
    s.bl = 40;
    do_txn(s, o);
    judge("write", s, o, 1'b0, exp_rsp_cyc(o.acc, s, exp_read(16, s.mask)));
  endtask

  task automatic test_read();
    stim_t s; obs_t o;
    s = base_stim(2, 24, 32'h5A000000, 32'hFF000000);
    s.bl = 8; s.rpulse = 1'b1; s.roff = 3; s.rd1 = 32'h00123456;
    do_txn(s, o);
    judge("read", s, o, 1'b0, exp_rsp_cyc(o.acc, s, 1'b1));
  endtask

  task automatic test_same_cycle_read();
    stim_t s; obs_t o;
    s = base_stim(1, 12, 32'h3C000000, 32'h00000000);
    s.bl = 5; s.rpulse = 1'b1; s.roff = 0; s.rd1 = 32'hCAFE0123;
    s.second = 1'b1; s.rd2 = 32'hDEADBEEF;
    do_txn(s, o);
    judge("same_cycle", s, o, 1'b0, exp_rsp_cyc(o.acc, s, 1'b1));
    s.roff = -1; s.rd1 = 32'h0000ABCD; s.rd2 = 32'h11111111;
    do_txn(s, o);
    judge("first_wins", s, o, 1'b0, exp_rsp_cyc(o.acc, s, 1'b1));
  endtask

  task automatic test_contention();
    int         last;
    int         ngr;
    logic [3:0] prev;
    logic [3:0] want;
    apply_reset();
    @(negedge fabric_clk);
    req_length = '0;
    req_valid  = '1;
    #1;
    last = -1; ngr = 0; prev = '0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (cyc > 0) begin
        @(negedge fabric_clk);
        #1;
      end
      if (req_ready != '0) begin
        if (ngr < 5) begin
          last = (last + 1) % NR;
          want = 4'(1 << last);
          vectors++;
          if (req_ready !== want) begin
            miscompares++; $display("[TB] FAIL contention_grant%0d: got %b need %b", ngr, req_ready, want);
          end
        end
        ngr++;
      end
      vectors++;
      if (prev != '0 && req_ready != '0) begin
        miscompares++; $display("[TB] FAIL contention_ready_width: got ready %b right after %b, need one cycle", req_ready, prev);
      end
      prev = req_ready;
    end
    vectors++;
    if (ngr < 5) begin
      miscompares++; $display("[TB] FAIL contention_count: got %0d grants need >= 5", ngr);
    end
    req_valid = '0;
  endtask

  task automatic test_timeout();
    stim_t s; obs_t o;
    s = base_stim(3, 8, 32'h77000000, 32'hFFFFFFFF);
    s.never = 1'b1;
    do_txn(s, o);
    judge("timeout", s, o, 1'b1, o.acc + 1 + TO + 1);
    s = base_stim(3, 8, 32'h12000000, 32'h00FFFFFF);
    s.rpulse = 1'b1; s.roff = 2; s.rd1 = 32'h000000A7;
    do_txn(s, o);
    judge("after_timeout", s, o, 1'b0, exp_rsp_cyc(o.acc, s, 1'b1));
  endtask

  task automatic test_boundaries();
    stim_t s; obs_t o;
    int    p;
    bit    seen;
    s = base_stim(1, 0, 32'hFFFFFFFF, 32'h00000000);
    do_txn(s, o);
    judge("len0", s, o, 1'b0, o.acc + 1);
    s = base_stim(2, 40, 32'h89ABCDEF, 32'hFFFFFFFF);
    do_txn(s, o);
    judge("len40", s, o, 1'b0, exp_rsp_cyc(o.acc, s, 1'b0));
    // Reset while the core is busy: the transaction must vanish without a response.
    @(negedge fabric_clk);
    req_length[1*LW +: LW] = 6'd8; req_data[1*DW +: DW] = 32'h12000000;
    req_rw_mask[1*DW +: DW] = 32'h00FFFFFF; req_valid[1] = 1'b1;
    #1;
    p = -1;
    for (int cyc = 0; cyc < 10 && p < 0; cyc++) begin
      if (cyc > 0) begin
        @(negedge fabric_clk);
        #1;
      end
      if (spi_transaction_length != '0) p = cyc;
    end
    vectors++;
    if (p < 0) begin
      miscompares++; $display("[TB] FAIL midreset_issue: got no length pulse, need one");
    end
    req_valid = '0; spi_busy = 1'b1;
    repeat (4) @(negedge fabric_clk);
    #1;
    reset = 1'b1;
    #1;
    vectors++;
    if ({req_ready, rsp_valid, rsp_data, rsp_error, spi_transaction_length,
         spi_transaction_data, spi_transaction_rw_mask} !== '0) begin
      miscompares++; $display("[TB] FAIL midreset_outputs: got nonzero outputs, need all 0");
    end
    @(negedge fabric_clk);
    reset = 1'b0;
    repeat (2) @(negedge fabric_clk);
    spi_busy = 1'b0; spi_read_valid = 1'b1; spi_read_data = 32'h55AA55AA;
    @(negedge fabric_clk);
    spi_read_valid = 1'b0; spi_read_data = '0;
    seen = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      #1;
      if (rsp_valid != '0) seen = 1'b1;
      @(negedge fabric_clk);
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++; $display("[TB] FAIL midreset_no_rsp: got rsp_valid after reset, need none");
    end
  endtask

  task automatic test_random();
    stim_t s; obs_t o;
    bit    rexp;
    for (int n = 0; n < 24; n++) begin
      s = base_stim($urandom_range(0, NR - 1), 0, $urandom, 32'h0);
      case ($urandom_range(0, 9))
        0:       s.len = 0;
        1:       s.len = $urandom_range(33, 63);
        default: s.len = $urandom_range(1, 32);
      endcase
      s.mask = ($urandom_range(0, 1) == 1) ? 32'hFFFFFFFF : 32'($urandom);
      s.sd   = $urandom_range(0, 3);
      s.bl   = $urandom_range(3, 12);
      s.rd1  = $urandom;
      s.rd2  = $urandom;
      rexp   = exp_read(exp_len(s.len), s.mask);
      if (rexp) begin
        s.rpulse = 1'b1;
        s.roff   = $urandom_range(0, 4) - 1;
        s.second = ($urandom_range(0, 1) == 1);
      end else begin
        s.rpulse = ($urandom_range(0, 1) == 1);
        s.roff   = 0;
      end
      do_txn(s, o);
      judge("random", s, o, 1'b0, exp_rsp_cyc(o.acc, s, rexp));
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_single_write();
    test_read();
    test_same_cycle_read();
    test_contention();
    test_timeout();
    test_boundaries();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
